import_config_sequencer: RTL and testbench
==========================================

# import_config_sequencer

Controller that sequences the loading of package-supplied configuration constants into three 10-bit configuration registers (a, b, c) over a shared single-port register write bus. It sits between the reset/bring-up logic and the configuration register file. A single start pulse writes a := Z, b := Z, c := Y in fixed order with a valid/ready handshake, then reports completion. A per-write timeout aborts the sequence if the register file stalls.

## Interface
Parameters:
- WIDTH, 10, data width of each configuration register and of the write bus.
- VAL_Z, 0, value written to registers a and b (constant z of the first config package).
- VAL_Y, 0, value written to register c (constant y of the second config package).
- TIMEOUT, 15, maximum cycles a write may wait for ready; legal range 1..255.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_start  input  1  start request; sampled only in IDLE or DONE or ERR.
- o_busy  output  1  high while a sequence is in progress (WR_A, WR_B, WR_C).
- o_done  output  1  one-cycle pulse when all three writes complete.
- o_err  output  1  sticky timeout flag; cleared by reset or by an accepted start.
- o_wr_valid  output  1  write request valid.
- o_wr_addr  output  2  target register: 0 = a, 1 = b, 2 = c; 3 never driven.
- o_wr_data  output  WIDTH  write data.
- i_wr_ready  input  1  register file accepts the write this cycle.
- o_a, o_b, o_c  output  WIDTH each  shadow copies of the last value successfully written to each register.

## Operation
- States: IDLE, WR_A, WR_B, WR_C, DONE, ERR.
- IDLE/DONE/ERR + i_start=1 -> WR_A; o_err cleared, timeout counter cleared.
- WR_A: o_wr_valid=1, addr=0, data=VAL_Z. WR_B: addr=1, data=VAL_Z. WR_C: addr=2, data=VAL_Y.
- Handshake = o_wr_valid && i_wr_ready in the same cycle. On handshake: the matching shadow register takes o_wr_data, the counter clears, and the FSM advances (WR_A->WR_B->WR_C->DONE).
- While valid && !ready: addr/data held stable and the counter increments. If the counter equals TIMEOUT-1 and ready is low, the FSM goes to ERR next cycle, o_err is set, and valid drops. If ready is high in that same cycle, the handshake wins and there is no error.
- DONE: o_done=1 for exactly the one cycle of entry; the FSM stays in DONE (o_done=0) until the next start.
- ERR: holds until start; shadow registers keep only the writes that completed.
- i_start while busy is ignored; there is no queued restart.
- Counter width is 8 bits; it never wraps because it is bounded by TIMEOUT.
- Outputs are registered state decodes; no combinational path from i_wr_ready to outputs except through state.

## Timing
- Reset values: state IDLE, o_busy=0, o_done=0, o_err=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_a=o_b=o_c=0, counter 0.
- Reset asserted mid-sequence returns to IDLE on the next edge: valid drops, shadows are zeroed, and no done is issued.
- Start sampled at edge t: o_wr_valid=1 and o_busy=1 from t+1.
- With ready tied high: handshakes at t+1, t+2, t+3; o_a updated at t+2, o_b at t+3, o_c at t+4; o_done pulses at t+4; o_busy low at t+4.
- Minimum sequence latency from start to done is 4 cycles; each stalled cycle adds 1.
- Timeout: valid asserted at cycle v with ready low throughout -> last possible handshake cycle is v+TIMEOUT-1; ERR (o_err=1, valid=0) at v+TIMEOUT.

## Test plan
- VAL_Z=5, VAL_Y=9, ready tied high, start at cycle 2 -> valid cycles 3-5 with addr 0,1,2 and data 5,5,9; o_done=1 only at cycle 6; o_a=5, o_b=5, o_c=9.
- Ready low for 3 cycles during WR_B -> addr=1/data=5 stable for 4 valid cycles; done 3 cycles later than the tied-high case; no error.
- TIMEOUT=4, ready never asserted -> valid high 4 cycles on addr 0, then o_err=1, valid=0; o_a=o_b=o_c=0; o_done never pulses.
- TIMEOUT=4, ready asserted exactly on the 4th valid cycle -> handshake accepted, o_err stays 0, sequence completes.
- i_start pulsed again during WR_B -> ignored; exactly one done. A start issued from ERR clears o_err and the rerun completes normally.
- i_rst asserted during WR_C -> next cycle all outputs are at reset values; a subsequent start runs the full sequence.

Source files
------------

// File: rtl/import_config_sequencer.sv
// Bring-up sequencer: writes a := VAL_Z, b := VAL_Z, c := VAL_Y over a valid/ready
// register write bus, with a per-write stall timeout that parks the sequence in ERR.
module import_config_sequencer #(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned VAL_Z   = 0,
    parameter int unsigned VAL_Y   = 0,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_wr_valid,
    output logic [1:0]       o_wr_addr,
    output logic [WIDTH-1:0] o_wr_data,
    input  logic             i_wr_ready,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [WIDTH-1:0] o_c
);

    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] DATA_Z   = WIDTH'(VAL_Z);
    localparam logic [WIDTH-1:0] DATA_Y   = WIDTH'(VAL_Y);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR_A = 3'd1,
        WR_B = 3'd2,
        WR_C = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // State, stall counter and all outputs move together so every output is a registered decode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= 2'd0;
            o_wr_data  <= '0;
            o_a        <= '0;
            o_b        <= '0;
            o_c        <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (i_start) begin
                        state      <= WR_A;
                        cnt        <= '0;
                        o_err      <= 1'b0;
                        o_busy     <= 1'b1;
                        o_wr_valid <= 1'b1;
                        o_wr_addr  <= 2'd0;
                        o_wr_data  <= DATA_Z;
                    end
                end
                WR_A, WR_B, WR_C: begin
                    if (i_wr_ready) begin
                        cnt <= '0;
                        case (state)
                            WR_A: begin
                                o_a       <= o_wr_data;
                                state     <= WR_B;
                                o_wr_addr <= 2'd1;
                                o_wr_data <= DATA_Z;
                            end
                            WR_B: begin
                                o_b       <= o_wr_data;
                                state     <= WR_C;
                                o_wr_addr <= 2'd2;
                                o_wr_data <= DATA_Y;
                            end
                            default: begin
                                o_c        <= o_wr_data;
                                state      <= DONE;
                                o_done     <= 1'b1;
                                o_busy     <= 1'b0;
                                o_wr_valid <= 1'b0;
                            end
                        endcase
                    end else if (cnt == CNT_LAST) begin
                        // Ready still low on the last allowed cycle: abandon the sequence.
                        state      <= ERR;
                        cnt        <= '0;
                        o_err      <= 1'b1;
                        o_busy     <= 1'b0;
                        o_wr_valid <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_import_config_sequencer.sv
// Directed bench for import_config_sequencer (VAL_Z=5, VAL_Y=9, TIMEOUT=4) with
// hand-computed cycle-by-cycle expectations.
module tb_import_config_sequencer;

    localparam int unsigned WIDTH = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             ready;
    logic             busy;
    logic             done;
    logic             err;
    logic             wr_valid;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    import_config_sequencer #(
        .WIDTH  (WIDTH),
        .VAL_Z  (5),
        .VAL_Y  (9),
        .TIMEOUT(4)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .o_busy    (busy),
        .o_done    (done),
        .o_err     (err),
        .o_wr_valid(wr_valid),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data),
        .i_wr_ready(ready),
        .o_a       (a),
        .o_b       (b),
        .o_c       (c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Control/bus outputs; addr and data are only meaningful while valid is high.
    task automatic chk_ctl(input string tag, input logic e_busy, input logic e_done,
                           input logic e_err, input logic e_valid,
                           input logic [1:0] e_addr, input logic [WIDTH-1:0] e_data);
        chk({tag, ".busy"},  32'(busy),     32'(e_busy));
        chk({tag, ".done"},  32'(done),     32'(e_done));
        chk({tag, ".err"},   32'(err),      32'(e_err));
        chk({tag, ".valid"}, 32'(wr_valid), 32'(e_valid));
        if (e_valid) begin
            chk({tag, ".addr"}, 32'(wr_addr), 32'(e_addr));
            chk({tag, ".data"}, 32'(wr_data), 32'(e_data));
        end
    endtask

    task automatic chk_shadow(input string tag, input logic [WIDTH-1:0] e_a,
                              input logic [WIDTH-1:0] e_b, input logic [WIDTH-1:0] e_c);
        chk({tag, ".a"}, 32'(a), 32'(e_a));
        chk({tag, ".b"}, 32'(b), 32'(e_b));
        chk({tag, ".c"}, 32'(c), 32'(e_c));
    endtask

    task automatic chk_reset(input string tag);
        chk_ctl(tag, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0);
        chk({tag, ".addr"}, 32'(wr_addr), 32'd0);
        chk({tag, ".data"}, 32'(wr_data), 32'd0);
        chk_shadow(tag, '0, '0, '0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();
        chk_reset("idle");

        // Ready tied high: three back-to-back writes, done four cycles after start.
        ready = 1'b1;
        pulse_start();
        chk_ctl("t1.wr_a", 1, 0, 0, 1, 2'd0, 10'd5);
        chk_shadow("t1.wr_a", 0, 0, 0);
        tick();
        chk_ctl("t1.wr_b", 1, 0, 0, 1, 2'd1, 10'd5);
        chk_shadow("t1.wr_b", 5, 0, 0);
        tick();
        chk_ctl("t1.wr_c", 1, 0, 0, 1, 2'd2, 10'd9);
        chk_shadow("t1.wr_c", 5, 5, 0);
        tick();
        chk_ctl("t1.done", 0, 1, 0, 0, 2'd0, '0);
        chk_shadow("t1.done", 5, 5, 9);
        tick();
        chk_ctl("t1.hold", 0, 0, 0, 0, 2'd0, '0);

        // Three stalled cycles in WR_B; release lands on counter == TIMEOUT-1.
        pulse_start();
        chk_ctl("t2.wr_a", 1, 0, 0, 1, 2'd0, 10'd5);
        tick();
        ready = 1'b0;
        chk_ctl("t2.stall1", 1, 0, 0, 1, 2'd1, 10'd5);
        tick();
        chk_ctl("t2.stall2", 1, 0, 0, 1, 2'd1, 10'd5);
        tick();
        chk_ctl("t2.stall3", 1, 0, 0, 1, 2'd1, 10'd5);
        tick();
        chk_ctl("t2.accept", 1, 0, 0, 1, 2'd1, 10'd5);
        ready = 1'b1;
        tick();
        chk_ctl("t2.wr_c", 1, 0, 0, 1, 2'd2, 10'd9);
        tick();
        chk_ctl("t2.done", 0, 1, 0, 0, 2'd0, '0);
        chk_shadow("t2.done", 5, 5, 9);

        // Reset from DONE zeroes shadows; then ready never comes and the write times out.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("t3.reset");
        ready = 1'b0;
        pulse_start();
        chk_ctl("t3.v1", 1, 0, 0, 1, 2'd0, 10'd5);
        tick();
        chk_ctl("t3.v2", 1, 0, 0, 1, 2'd0, 10'd5);
        tick();
        chk_ctl("t3.v3", 1, 0, 0, 1, 2'd0, 10'd5);
        tick();
        chk_ctl("t3.v4", 1, 0, 0, 1, 2'd0, 10'd5);
        tick();
        chk_ctl("t3.err", 0, 0, 1, 0, 2'd0, '0);
        chk_shadow("t3.err", 0, 0, 0);
        tick();
        chk_ctl("t3.sticky", 0, 0, 1, 0, 2'd0, '0);

        // Restart from ERR; ready on the 4th valid cycle wins; extra start in WR_B ignored.
        pulse_start();
        chk_ctl("t4.v1", 1, 0, 0, 1, 2'd0, 10'd5);
        tick();
        tick();
        tick();
        chk_ctl("t4.v4", 1, 0, 0, 1, 2'd0, 10'd5);
        ready = 1'b1;
        tick();
        chk_ctl("t4.wr_b", 1, 0, 0, 1, 2'd1, 10'd5);
        chk_shadow("t4.wr_b", 5, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_ctl("t4.wr_c", 1, 0, 0, 1, 2'd2, 10'd9);
        tick();
        chk_ctl("t4.done", 0, 1, 0, 0, 2'd0, '0);
        chk_shadow("t4.done", 5, 5, 9);
        tick();
        chk_ctl("t4.after1", 0, 0, 0, 0, 2'd0, '0);
        tick();
        chk_ctl("t4.after2", 0, 0, 0, 0, 2'd0, '0);

        // Reset during WR_C, then a clean full rerun.
        pulse_start();
        tick();
        tick();
        chk_ctl("t5.wr_c", 1, 0, 0, 1, 2'd2, 10'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("t5.reset");
        tick();
        chk_reset("t5.idle");
        pulse_start();
        chk_ctl("t5.wr_a", 1, 0, 0, 1, 2'd0, 10'd5);
        tick();
        tick();
        tick();
        chk_ctl("t5.done", 0, 1, 0, 0, 2'd0, '0);
        chk_shadow("t5.done", 5, 5, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
